uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clock cycles per serial bit (range 4..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the receive buffer depth in bytes (power of two, 2..16).
REQ-003 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high, 8 data bits LSB first, 1 stop bit.
REQ-006 SHALL have port out_data  output  8  byte at the FIFO head.
REQ-007 SHALL have port out_valid  output  1  high while the FIFO is non-empty.
REQ-008 SHALL have port out_ready  input  1  consumer accepts the head byte when high together with out_valid.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse when a complete byte is dropped because the FIFO is full.
REQ-011 SHALL have port parity_err  output  1  one-cycle pulse on a parity mismatch, and constant 0 when parity is compiled out.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer before any use, adding 2 cycles of input latency.
REQ-013 SHALL implement an FSM with states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE; PARITY exists only with the macro defined.
REQ-014 IDLE->START SHALL occur on a synchronized high-to-low transition of rx.
REQ-015 START SHALL sample rx at CLKS_PER_BIT/2 (integer division) cycles; low -> DATA, high -> IDLE (false start, no output).
REQ-016 DATA SHALL sample 8 bits, one every CLKS_PER_BIT cycles, shifted in LSB first.
REQ-017 STOP SHALL sample rx after CLKS_PER_BIT cycles; high -> byte complete, IDLE.
REQ-018 A low stop sample SHALL pulse frame_err, discard the byte and enter WAIT_IDLE; WAIT_IDLE -> IDLE when synchronized rx is high.
REQ-019 A completed byte SHALL be written to the FIFO on the stop-sample edge, with out_valid high from the next cycle when the FIFO was empty.
REQ-020 A pop SHALL occur on any cycle where out_valid and out_ready are both high; out_data SHALL then show the next entry in the following cycle.
REQ-021 With the FIFO full and no pop in the same cycle, a completed byte SHALL be dropped and overrun pulsed; FIFO contents SHALL be unchanged.
REQ-022 With the FIFO full and a pop in the same cycle, the push SHALL succeed and overrun SHALL stay low.
REQ-023 A simultaneous push and pop on an empty FIFO SHALL not occur, because out_valid is low.
REQ-024 Pointers SHALL be log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH; an entry count of log2(FIFO_DEPTH)+1 bits SHALL distinguish full from empty.
REQ-025 out_data SHALL be 0 when the FIFO is empty.
REQ-026 frame_err, overrun and parity_err SHALL never remain high for more than one consecutive cycle.

Reset
REQ-027 Asserting reset SHALL immediately force: FSM to IDLE, bit and baud counters to 0, FIFO empty, synchronizer flops to 1.
REQ-028 Asserting reset SHALL immediately force: out_data 0, out_valid 0, frame_err 0, overrun 0, parity_err 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame; no partial byte SHALL ever reach the FIFO.
REQ-030 After reset deasserts with rx low, the block SHALL not detect a start until rx has been seen high.

Configuration
REQ-031 Macro UART_RX_PARITY_EN SHALL, when defined, insert the PARITY state between DATA and STOP to sample one even-parity bit after CLKS_PER_BIT cycles.
REQ-032 With UART_RX_PARITY_EN defined, a mismatch SHALL pulse parity_err at the stop sample and discard the byte; a framing error takes precedence and suppresses parity_err.
REQ-033 Without UART_RX_PARITY_EN, frames SHALL be 10 bits, no PARITY state SHALL exist, and parity_err SHALL be tied 0.

Verification (CLKS_PER_BIT=8, FIFO_DEPTH=4)
REQ-034 Send 0xA5, out_ready=1 -> out_valid one cycle, out_data=0xA5, no error pulses.
REQ-035 Send 0x01,0x02,0x03,0x04,0x05 with out_ready=0 -> overrun pulses once on 0x05; then draining yields 0x01..0x04 and out_valid drops.
REQ-036 Send 0x3C with stop bit low -> frame_err pulse, FIFO stays empty; a following 0x3C once rx returns high -> received correctly.
REQ-037 Low glitch on rx of 2 cycles -> no start, no output, FSM back in IDLE.
REQ-038 Assert reset at data bit 4 of 0xFF, then send 0x55 -> only 0x55 output.
REQ-039 With UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 -> parity_err pulse, no output; with parity bit 1 -> 0x07 output.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (8 data bits, LSB first, 1 stop bit) feeding a FIFO_DEPTH-byte FIFO; UART_RX_PARITY_EN adds an even-parity bit.
// Latency: 2-cycle input synchronizer, byte visible the cycle after its stop sample; no backpressure on rx, full FIFO drops and pulses overrun.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0]     HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0]     BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
  localparam logic [AW:0]     CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]     CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

  logic          r_sync1;
  logic          r_sync2;
  logic          r_rx_prev;
  logic [1:0]    r_flush;
  state_t        r_state;
  logic [15:0]   r_baud_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_frame_err;
  logic          r_overrun;
`ifdef UART_RX_PARITY_EN
  logic          r_par_bit;
  logic          r_parity_err;
`endif

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_start;
  logic          w_bit_end;
  logic          w_par_ok;
  logic          w_byte_done;
  logic          w_full;
  logic          w_pop;
  logic          w_push;

  // r_rx_prev stays 0 until the reset value has left the synchronizer, so a line
  // held low through reset must first be seen high before a start can be detected.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_flush   <= 2'b00;
      r_rx_prev <= 1'b0;
    end else begin
      r_sync1   <= rx;
      r_sync2   <= r_sync1;
      r_flush   <= {r_flush[0], 1'b1};
      r_rx_prev <= r_sync2 & r_flush[1];
    end
  end

  assign w_start   = r_rx_prev & ~r_sync2;
  assign w_bit_end = (r_baud_cnt == BIT_LAST);

`ifdef UART_RX_PARITY_EN
  assign w_par_ok = ~^{r_shift, r_par_bit};
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_byte_done = (r_state == STOP) && w_bit_end && r_sync2 && w_par_ok;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_baud_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          r_baud_cnt <= '0;
          if (w_start) r_state <= START;
        end
        START: begin
          if (r_baud_cnt == HALF_LAST) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_state    <= r_sync2 ? IDLE : DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_shift    <= {r_sync2, r_shift[7:1]};
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_par_bit  <= r_sync2;
            r_state    <= STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
`endif
        STOP: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (!r_sync2) begin
              r_frame_err <= 1'b1;
              r_state     <= WAIT_IDLE;
            end else begin
`ifdef UART_RX_PARITY_EN
              r_parity_err <= ~w_par_ok;
`endif
              r_state <= IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        WAIT_IDLE: begin
          if (r_sync2) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_full = (r_count == CNT_FULL);
  assign w_pop  = out_valid & out_ready;
  assign w_push = w_byte_done & (~w_full | w_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_byte_done & w_full & ~w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // A push into a full FIFO with a same-cycle pop overwrites the slot being read out.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= r_shift;
  end

  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule
